// File: rtl/dpram_ctrl_pkg.sv
// Shared types and helpers for the DPRAM port controller.
//   ctrl_state_t : controller FSM states (INIT sweep, then RUN)
//   rr_pick      : round-robin one-hot pick from a request vector, searching
//                  upward from ptr and wrapping modulo num_req
package dpram_ctrl_pkg;

  localparam int unsigned MAX_REQ   = 4;
  localparam int unsigned MAX_PTR_W = 2;

  typedef enum logic {ST_INIT, ST_RUN} ctrl_state_t;

  // First asserted request at or above ptr, wrapping within num_req lanes.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0]   req,
    input logic [MAX_PTR_W-1:0] ptr,
    input int unsigned          num_req
  );
    logic [MAX_REQ-1:0] gnt;
    logic               found;
    int unsigned        idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = (32'(ptr) + k) % num_req;
      if ((k < num_req) && !found && req[MAX_PTR_W'(idx)]) begin
        gnt[MAX_PTR_W'(idx)] = 1'b1;
        found                = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for one RAM port.
//   clk, rst : clock, asynchronous active-low reset
//   en       : arbitration enabled (controller in RUN)
//   req      : per-requester valid
//   gnt      : one-hot grant, combinational from req and the pointer
module rr_arbiter
  import dpram_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   ptr_next;
  logic [MAX_REQ-1:0] pick_all;

  // Grant decode; pointer moves to one past the winner, holds when idle.
  always_comb begin
    pick_all = rr_pick(MAX_REQ'(req), MAX_PTR_W'(ptr), NUM_REQ);
    gnt      = en ? NUM_REQ'(pick_all) : '0;
    ptr_next = ptr;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) ptr_next = PTR_W'((i + 1) % NUM_REQ);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr <= '0;
    else      ptr <= ptr_next;
  end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Controller in front of a simple dual-port RAM. Sweeps every word to
// INIT_VALUE after reset, then shares the write and read ports between
// NUM_REQ requesters with independent round-robin arbitration.
//   wr_req/wr_addr/wr_data/wr_gnt : write requesters (packed per lane)
//   rd_req/rd_addr/rd_gnt         : read requesters (packed per lane)
//   rsp_valid/rsp_id/rsp_data     : read response, one cycle after grant
//   init_done                     : high once the sweep has finished
//   ram_*                         : connection to the DPRAM instance
module dpram_port_arbiter
  import dpram_ctrl_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH = 4,
  parameter int unsigned          DATA_WIDTH = 8,
  parameter int unsigned          DEPTH      = 16,
  parameter int unsigned          NUM_REQ    = 2,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  localparam int unsigned         ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            wr_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data,
  output logic [NUM_REQ-1:0]            wr_gnt,
  input  logic [NUM_REQ-1:0]            rd_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_REQ-1:0]            rd_gnt,
  output logic                          rsp_valid,
  output logic [ID_W-1:0]               rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          init_done,
  output logic                          ram_wr_en,
  output logic [ADDR_WIDTH-1:0]         ram_wr_addr,
  output logic [DATA_WIDTH-1:0]         ram_wr_data,
  output logic                          ram_rd_en,
  output logic [ADDR_WIDTH-1:0]         ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]         ram_rd_data
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  ctrl_state_t           state;
  ctrl_state_t           state_next;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  run;
  logic [ID_W-1:0]       wr_idx;
  logic [ID_W-1:0]       rd_idx;

  assign run = (state == ST_RUN);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
    .clk (clk),
    .rst (rst),
    .en  (run),
    .req (wr_req),
    .gnt (wr_gnt)
  );

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
    .clk (clk),
    .rst (rst),
    .en  (run),
    .req (rd_req),
    .gnt (rd_gnt)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_INIT;
    else      state <= state_next;
  end

  // Next state and RAM port muxes.
  always_comb begin
    state_next  = state;
    wr_idx      = '0;
    rd_idx      = '0;
    ram_wr_en   = 1'b0;
    ram_wr_addr = '0;
    ram_wr_data = '0;
    ram_rd_en   = 1'b0;
    ram_rd_addr = '0;

    case (state)
      ST_INIT: if (init_cnt == LAST_ADDR) state_next = ST_RUN;
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_INIT;
    endcase

    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (wr_gnt[i]) wr_idx = ID_W'(i);
      if (rd_gnt[i]) rd_idx = ID_W'(i);
    end

    // Gated by rst so the RAM sees no write while reset is held.
    if ((state == ST_INIT) && rst) begin
      ram_wr_en   = 1'b1;
      ram_wr_addr = init_cnt;
      ram_wr_data = INIT_VALUE;
    end else if (run) begin
      ram_wr_en   = |wr_gnt;
      ram_wr_addr = wr_addr[32'(wr_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      ram_wr_data = wr_data[32'(wr_idx)*DATA_WIDTH +: DATA_WIDTH];
      ram_rd_en   = |rd_gnt;
      ram_rd_addr = rd_addr[32'(rd_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // Sweep counter, init flag and response tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_cnt  <= '0;
      init_done <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
    end else begin
      if (state == ST_INIT) init_cnt <= init_cnt + ADDR_WIDTH'(1);
      init_done <= (state_next == ST_RUN);
      rsp_valid <= |rd_gnt;
      if (|rd_gnt) rsp_id <= rd_idx;
    end
  end

  // RAM read data already lags the grant by one cycle, aligned with rsp_valid.
  assign rsp_data = ram_rd_data;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Self-checking bench for dpram_port_arbiter with an attached DPRAM model.
module tb_dpram_port_arbiter;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned NR = 2;

  logic clk = 1'b0;
  logic rst;
  logic [NR-1:0]    wr_req, rd_req, wr_gnt, rd_gnt;
  logic [NR*AW-1:0] wr_addr, rd_addr;
  logic [NR*DW-1:0] wr_data;
  logic             rsp_valid, init_done;
  logic [0:0]       rsp_id;
  logic [DW-1:0]    rsp_data;
  logic             ram_wr_en, ram_rd_en;
  logic [AW-1:0]    ram_wr_addr, ram_rd_addr;
  logic [DW-1:0]    ram_wr_data, ram_rd_data;

  always #5 clk = ~clk;

  dpram_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_REQ(NR), .INIT_VALUE(8'h00)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .init_done(init_done),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
  );

  // Attached DPRAM: registered read returning the pre-write contents.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (ram_wr_en) ram[ram_wr_addr] <= ram_wr_data;
    if (ram_rd_en) ram_rd_data <= ram[ram_rd_addr];
  end

  int total = 0;
  int bad   = 0;

  // Reference model: memory contents, round-robin pointers, pending response.
  int            m_wptr, m_rptr, m_rid;
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_rv;
  logic [DW-1:0] m_rdata;

  function automatic int pick(input logic [NR-1:0] req, input int ptr);
    int idx;
    for (int k = 0; k < NR; k++) begin
      idx = (ptr + k) % NR;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [NR-1:0] onehot(input int i);
    return (i >= 0) ? NR'(1 << i) : '0;
  endfunction

  task automatic model_reset();
    m_wptr = 0; m_rptr = 0; m_rv = 0; m_rid = 0; m_rdata = '0;
    for (int a = 0; a < DEPTH; a++) m_mem[a] = 8'h00;
  endtask

  // Apply this cycle's transfers to the model, then move to the next negedge.
  task automatic advance(input int wi, input int ri);
    if (ri >= 0) begin
      m_rdata = m_mem[rd_addr[ri*AW +: AW]];
      m_rid = ri; m_rptr = (ri + 1) % NR; m_rv = 1;
    end else m_rv = 0;
    if (wi >= 0) begin
      m_mem[wr_addr[wi*AW +: AW]] = wr_data[wi*DW +: DW];
      m_wptr = (wi + 1) % NR;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    wr_req = '0; rd_req = '0; wr_addr = '0; rd_addr = '0; wr_data = '0;
    rst = 1'b1; #2 rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({wr_gnt, rd_gnt, ram_wr_en, ram_rd_en, rsp_valid, init_done} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%b exp=0", {wr_gnt, rd_gnt, ram_wr_en, ram_rd_en, rsp_valid, init_done});
    end
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      total++;
      if (ram_wr_en !== 1'b1 || ram_wr_addr !== AW'(i) || ram_wr_data !== 8'h00 ||
          wr_gnt !== '0 || rd_gnt !== '0 || init_done !== 1'b0) begin
        bad++; $display("FAIL sweep_%0d got en=%b a=%0d d=%h wg=%b rg=%b done=%b exp en=1 a=%0d d=00", i,
                        ram_wr_en, ram_wr_addr, ram_wr_data, wr_gnt, rd_gnt, init_done, i);
      end
      advance(-1, -1);
    end
    #1;
    total++;
    if (init_done !== 1'b1 || ram_wr_en !== 1'b0 || ram_rd_en !== 1'b0) begin
      bad++; $display("FAIL init_done got done=%b wen=%b ren=%b exp 1 0 0", init_done, ram_wr_en, ram_rd_en);
    end
    advance(-1, -1);
  endtask

  task automatic test_rr_write();
    logic [NR-1:0] seq [4];
    int wi, ri;
    seq = '{2'b01, 2'b10, 2'b01, 2'b10};
    wr_req = 2'b11;
    wr_addr[0 +: AW] = 4'd3; wr_addr[AW +: AW] = 4'd5;
    wr_data = NR*DW'($urandom);
    for (int c = 0; c < 4; c++) begin
      #1;
      wi = pick(wr_req, m_wptr);
      total++;
      if (wr_gnt !== seq[c] || wr_gnt !== onehot(wi) || ram_wr_en !== 1'b1 ||
          ram_wr_addr !== wr_addr[wi*AW +: AW] || ram_wr_data !== wr_data[wi*DW +: DW]) begin
        bad++; $display("FAIL rr_write_%0d got g=%b a=%0d d=%h exp g=%b a=%0d d=%h", c, wr_gnt,
                        ram_wr_addr, ram_wr_data, seq[c], wr_addr[wi*AW +: AW], wr_data[wi*DW +: DW]);
      end
      advance(wi, -1);
      wr_data[wi*DW +: DW] = DW'($urandom);
    end
    wr_req = '0;
    rd_req = 2'b11;
    rd_addr[0 +: AW] = 4'd3; rd_addr[AW +: AW] = 4'd5;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (rsp_valid !== m_rv || (m_rv && (rsp_id !== 1'(m_rid) || rsp_data !== m_rdata))) begin
        bad++; $display("FAIL rr_readback_%0d got v=%b id=%0d d=%h exp v=%b id=%0d d=%h", c,
                        rsp_valid, rsp_id, rsp_data, m_rv, m_rid, m_rdata);
      end
      ri = pick(rd_req, m_rptr);
      total++;
      if (rd_gnt !== onehot(ri)) begin
        bad++; $display("FAIL rr_read_gnt_%0d got=%b exp=%b", c, rd_gnt, onehot(ri));
      end
      advance(-1, ri);
      if (ri >= 0) rd_req[ri] = 1'b0;
    end
  endtask

  task automatic test_write_then_read();
    wr_req = 2'b01; wr_addr[0 +: AW] = 4'd7; wr_data[0 +: DW] = 8'hA5;
    #1;
    total++;
    if (wr_gnt !== 2'b01 || ram_wr_en !== 1'b1 || ram_wr_addr !== 4'd7 || ram_wr_data !== 8'hA5) begin
      bad++; $display("FAIL wtr_write got g=%b en=%b a=%0d d=%h exp 01 1 7 a5", wr_gnt, ram_wr_en, ram_wr_addr, ram_wr_data);
    end
    advance(0, -1);
    wr_req = '0; rd_req = 2'b10; rd_addr[AW +: AW] = 4'd7;
    #1;
    total++;
    if (rd_gnt !== 2'b10 || ram_rd_en !== 1'b1 || ram_rd_addr !== 4'd7) begin
      bad++; $display("FAIL wtr_read got g=%b en=%b a=%0d exp 10 1 7", rd_gnt, ram_rd_en, ram_rd_addr);
    end
    advance(-1, 1);
    rd_req = '0;
    #1;
    total++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 8'hA5 || rsp_data !== m_rdata) begin
      bad++; $display("FAIL wtr_rsp got v=%b id=%0d d=%h exp v=1 id=1 d=a5", rsp_valid, rsp_id, rsp_data);
    end
    advance(-1, -1);
  endtask

  task automatic test_same_addr();
    wr_req = 2'b01; wr_addr[0 +: AW] = 4'd2; wr_data[0 +: DW] = 8'h3C;
    rd_req = 2'b01; rd_addr[0 +: AW] = 4'd2;
    #1;
    total++;
    if (wr_gnt !== 2'b01 || rd_gnt !== 2'b01) begin
      bad++; $display("FAIL same_gnt got wg=%b rg=%b exp 01 01", wr_gnt, rd_gnt);
    end
    advance(0, 0);
    wr_req = '0;
    #1;
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'h00 || rsp_data !== m_rdata) begin
      bad++; $display("FAIL same_old got v=%b d=%h exp v=1 d=00", rsp_valid, rsp_data);
    end
    advance(-1, 0);
    rd_req = '0;
    #1;
    total++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 8'h3C) begin
      bad++; $display("FAIL same_new got v=%b id=%0d d=%h exp v=1 id=0 d=3c", rsp_valid, rsp_id, rsp_data);
    end
    advance(-1, -1);
  endtask

  task automatic test_read_stream();
    rd_req = 2'b10;
    for (int a = 0; a <= 4; a++) begin
      if (a == 4) rd_req = '0;
      else rd_addr[AW +: AW] = AW'(a);
      #1;
      total++;
      if (rsp_valid !== m_rv || (m_rv && (rsp_id !== 1'b1 || rsp_data !== m_rdata))) begin
        bad++; $display("FAIL stream_rsp_%0d got v=%b id=%0d d=%h exp v=%b id=1 d=%h", a,
                        rsp_valid, rsp_id, rsp_data, m_rv, m_rdata);
      end
      if (a < 4) begin
        total++;
        if (rd_gnt !== 2'b10) begin
          bad++; $display("FAIL stream_gnt_%0d got=%b exp=10", a, rd_gnt);
        end
        advance(-1, 1);
      end else advance(-1, -1);
    end
  endtask

  task automatic test_random(input int n);
    int wi, ri;
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!wr_req[i] && $urandom_range(1, 0) == 1) begin
          wr_req[i] = 1'b1; wr_addr[i*AW +: AW] = AW'($urandom); wr_data[i*DW +: DW] = DW'($urandom);
        end
        if (!rd_req[i] && $urandom_range(1, 0) == 1) begin
          rd_req[i] = 1'b1; rd_addr[i*AW +: AW] = AW'($urandom);
        end
      end
      if (c == n - 1) begin wr_req = '0; rd_req = '0; end
      #1;
      total++;
      if (rsp_valid !== m_rv || (m_rv && (rsp_id !== 1'(m_rid) || rsp_data !== m_rdata))) begin
        bad++; $display("FAIL rand_rsp_%0d got v=%b id=%0d d=%h exp v=%b id=%0d d=%h", c,
                        rsp_valid, rsp_id, rsp_data, m_rv, m_rid, m_rdata);
      end
      wi = pick(wr_req, m_wptr);
      ri = pick(rd_req, m_rptr);
      total++;
      if (wr_gnt !== onehot(wi) || rd_gnt !== onehot(ri) ||
          ram_wr_en !== (wi >= 0) || ram_rd_en !== (ri >= 0) ||
          (wi >= 0 && (ram_wr_addr !== wr_addr[wi*AW +: AW] || ram_wr_data !== wr_data[wi*DW +: DW])) ||
          (ri >= 0 && ram_rd_addr !== rd_addr[ri*AW +: AW])) begin
        bad++; $display("FAIL rand_port_%0d got wg=%b rg=%b wa=%0d wd=%h ra=%0d exp wg=%b rg=%b", c,
                        wr_gnt, rd_gnt, ram_wr_addr, ram_wr_data, ram_rd_addr, onehot(wi), onehot(ri));
      end
      advance(wi, ri);
      if (wi >= 0) wr_req[wi] = 1'b0;
      if (ri >= 0) rd_req[ri] = 1'b0;
    end
  endtask

  task automatic test_reset_mid_sweep();
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    wr_req = 2'b11; rd_req = 2'b11;
    wr_addr = NR*AW'($urandom); rd_addr = NR*AW'($urandom); wr_data = NR*DW'($urandom);
    rst = 1'b1;
    for (int i = 0; i <= 9; i++) begin
      #1;
      total++;
      if (ram_wr_en !== 1'b1 || ram_wr_addr !== AW'(i) || wr_gnt !== '0 || rd_gnt !== '0) begin
        bad++; $display("FAIL mid_sweep_%0d got en=%b a=%0d wg=%b rg=%b exp en=1 a=%0d", i,
                        ram_wr_en, ram_wr_addr, wr_gnt, rd_gnt, i);
      end
      if (i < 9) advance(-1, -1);
    end
    rst = 1'b0;
    #1;
    total++;
    if ({wr_gnt, rd_gnt, ram_wr_en, ram_rd_en, rsp_valid, init_done} !== '0) begin
      bad++; $display("FAIL mid_reset_outputs got=%b exp=0", {wr_gnt, rd_gnt, ram_wr_en, ram_rd_en, rsp_valid, init_done});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      total++;
      if (ram_wr_en !== 1'b1 || ram_wr_addr !== AW'(i) || ram_wr_data !== 8'h00 ||
          wr_gnt !== '0 || rd_gnt !== '0 || init_done !== 1'b0) begin
        bad++; $display("FAIL resweep_%0d got en=%b a=%0d d=%h wg=%b rg=%b done=%b exp en=1 a=%0d", i,
                        ram_wr_en, ram_wr_addr, ram_wr_data, wr_gnt, rd_gnt, init_done, i);
      end
      advance(-1, -1);
    end
    #1;
    total++;
    if (init_done !== 1'b1 || wr_gnt !== 2'b01 || rd_gnt !== 2'b01) begin
      bad++; $display("FAIL resweep_run got done=%b wg=%b rg=%b exp 1 01 01", init_done, wr_gnt, rd_gnt);
    end
    advance(0, 0);
    wr_req[0] = 1'b0; rd_req[0] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rr_write();
    test_write_then_read();
    test_same_addr();
    test_read_stream();
    test_random(200);
    test_reset_mid_sweep();
    test_random(100);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
